uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_defs.sv | 16 +
 rtl/sync_2ff.sv | 27 ++
 rtl/uart_rx.sv | 142 ++++++++++++++
 tb/tb_uart_rx.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_defs.sv
// Shared UART definitions: FSM state encodings and default bit timing,
// used by both the receiver and the transmitter.
package uart_defs;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START_BIT = 3'd1,
        S_DATA_BIT  = 3'd2,
        S_STOP_BIT  = 3'd3,
        S_WAIT_HIGH = 3'd4
    } state_e;

    // 100 MHz clock, 9600 baud
    localparam int CYCLES_DEFAULT = 10416;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// RST_VAL selects the value both flops take during reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1, mid-bit sampling, single-entry holding register
// with valid/ready handoff, frame-error and overrun pulses.
module uart_rx
    import uart_defs::*;
#(
    parameter int CYCLES = CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CW = (CYCLES > 2) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);
    localparam logic [CW-1:0] HALF = CW'(CYCLES / 2 - 1);

    logic          rx_s;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (in),
        .q   (rx_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;

        if (valid_q && ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    cnt_d   = '0;
                    state_d = S_START_BIT;
                end
            end
            S_START_BIT: begin
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? S_IDLE : S_DATA_BIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA_BIT: begin
                if (cnt_q == LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP_BIT;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP_BIT: begin
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = S_IDLE;
                        // Consumer taking the old byte this cycle frees the slot.
                        if (!valid_q || ready) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_HIGH: begin
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at CYCLES=16: vector table, directed
// corner cases, and random frames against a byte-queue reference model.
module tb_uart_rx;

    localparam int CYC = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_line = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_pass = 0;
    int n_tot  = 0;

    logic [7:0] acc_q[$];
    int n_ferr = 0;
    int n_ovr  = 0;
    int n_busy = 0;

    typedef struct {
        logic [7:0] d;
        logic       stop;
        int         stop_len;
        int         exp_acc;
        int         exp_ferr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[7];

    uart_rx #(.CYCLES(CYC)) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (rx_line),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Outputs are observed mid-cycle; valid&&ready here is a handshake
    // that completes on the following rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid && ready) acc_q.push_back(data);
            if (frame_err) n_ferr++;
            if (overrun) n_ovr++;
            if (busy) n_busy++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic clear_mon();
        acc_q.delete();
        n_ferr = 0;
        n_ovr  = 0;
        n_busy = 0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_val,
                              input int stop_len);
        rx_line = 1'b0;
        repeat (CYC) tick();
        for (int i = 0; i < 8; i++) begin
            rx_line = d[i];
            repeat (CYC) tick();
        end
        rx_line = stop_val;
        repeat (CYC * stop_len) tick();
        rx_line = 1'b1;
    endtask

    logic [7:0] exp_q[$];
    int         exp_ferr;

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1, 1, 0, 8'hA5};
        vecs[1] = '{8'h00, 1'b1, 1, 1, 0, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, 1, 1, 0, 8'hFF};
        vecs[3] = '{8'h3C, 1'b0, 3, 0, 1, 8'h00};
        vecs[4] = '{8'h55, 1'b1, 1, 1, 0, 8'h55};
        vecs[5] = '{8'h80, 1'b1, 1, 1, 0, 8'h80};
        vecs[6] = '{8'h01, 1'b1, 1, 1, 0, 8'h01};

        repeat (3) tick();
        chk("reset_outs", {data, valid, frame_err, overrun, busy}, 32'h0);
        rst = 1'b0;
        repeat (4) tick();

        for (int i = 0; i < 7; i++) begin
            clear_mon();
            send_frame(vecs[i].d, vecs[i].stop, vecs[i].stop_len);
            repeat (2 * CYC) tick();
            chk("tab_nvalid", acc_q.size(), vecs[i].exp_acc);
            chk("tab_ferr", n_ferr, vecs[i].exp_ferr);
            chk("tab_ovr", n_ovr, 0);
            chk("tab_busy", busy, 0);
            if (vecs[i].exp_acc == 1 && acc_q.size() > 0)
                chk("tab_data", acc_q[0], vecs[i].exp_data);
        end

        // short low glitch: start bit rejected after half a bit
        clear_mon();
        rx_line = 1'b0;
        repeat (6) tick();
        rx_line = 1'b1;
        repeat (2 * CYC) tick();
        chk("glitch_valid", acc_q.size(), 0);
        chk("glitch_ferr", n_ferr, 0);
        chk("glitch_busy_cycles", n_busy, CYC / 2);
        chk("glitch_idle", busy, 0);

        // holding register full: second byte dropped
        clear_mon();
        ready = 1'b0;
        send_frame(8'h11, 1'b1, 1);
        send_frame(8'h22, 1'b1, 1);
        repeat (2 * CYC) tick();
        chk("ovr_valid", valid, 1);
        chk("ovr_data", data, 8'h11);
        chk("ovr_pulses", n_ovr, 1);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("ovr_drain", valid, 0);
        chk("ovr_nacc", acc_q.size(), 1);

        // ready pulse on the very cycle the stop bit is sampled
        clear_mon();
        send_frame(8'h42, 1'b1, 1);
        repeat (CYC) tick();
        chk("hold_data", data, 8'h42);
        fork
            send_frame(8'h81, 1'b1, 1);
            begin
                repeat (3 + CYC / 2 + 9 * CYC - 1) tick();
                ready = 1'b1;
                tick();
                ready = 1'b0;
                chk("swap_valid", valid, 1);
                chk("swap_data", data, 8'h81);
            end
        join
        repeat (CYC) tick();
        chk("swap_ovr", n_ovr, 0);
        chk("swap_nacc", acc_q.size(), 1);
        ready = 1'b1;
        repeat (2) tick();

        // reset during bit 4 aborts the frame
        clear_mon();
        fork
            send_frame(8'hF0, 1'b1, 1);
            begin
                repeat (CYC * 5 + CYC / 2) tick();
                rst = 1'b1;
                tick();
                chk("rst_outs", {data, valid, frame_err, overrun, busy}, 32'h0);
                rst = 1'b0;
            end
        join
        repeat (CYC) tick();
        chk("rst_nacc", acc_q.size(), 0);
        chk("rst_ferr", n_ferr + n_ovr, 0);
        send_frame(8'h0F, 1'b1, 1);
        repeat (2 * CYC) tick();
        chk("rst_next_n", acc_q.size(), 1);
        if (acc_q.size() > 0) chk("rst_next_data", acc_q[0], 8'h0F);

        // random frames, good and bad stop bits, random idle gaps
        clear_mon();
        exp_ferr = 0;
        for (int i = 0; i < 20; i++) begin
            logic [7:0] d;
            logic       ok;
            int         gap;
            d   = 8'($urandom);
            ok  = ($urandom_range(0, 3) != 0);
            gap = $urandom_range(0, 2 * CYC);
            if (ok) begin
                exp_q.push_back(d);
                send_frame(d, 1'b1, 1);
            end else begin
                exp_ferr++;
                send_frame(d, 1'b0, 1 + $urandom_range(0, 2));
                gap = gap + CYC;
            end
            repeat (gap) tick();
        end
        repeat (2 * CYC) tick();
        chk("rnd_count", acc_q.size(), exp_q.size());
        chk("rnd_ferr", n_ferr, exp_ferr);
        chk("rnd_ovr", n_ovr, 0);
        for (int i = 0; i < exp_q.size(); i++)
            chk("rnd_data", (i < acc_q.size()) ? {24'h0, acc_q[i]} : 32'hDEAD,
                exp_q[i]);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
